// File: rtl/jtag_uart_responder_pkg.sv
// Shared definitions for the JTAG UART responder: register map selectors,
// CONTROL/DATA bit positions, the read FSM state type and word packers.
package jtag_uart_pkg;

  // address[2] selects the register; address[1:0] is don't-care
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // Bit positions inside the DATA and CONTROL words
  localparam int BIT_RE     = 0;
  localparam int BIT_WE     = 1;
  localparam int BIT_RI     = 8;
  localparam int BIT_WI     = 9;
  localparam int BIT_OVF    = 10;
  localparam int BIT_RVALID = 15;
  localparam int OFS_RAVAIL = 16;
  localparam int OFS_WSPACE = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rd_state_e;

  // DATA read word for a non-empty RX FIFO
  function automatic logic [31:0] data_word(input logic [15:0] ravail,
                                            input logic [7:0]  rx_byte);
    logic [31:0] w;
    w                      = '0;
    w[OFS_RAVAIL +: 16]    = ravail;
    w[BIT_RVALID]          = 1'b1;
    w[7:0]                 = rx_byte;
    return w;
  endfunction

  // CONTROL read word
  function automatic logic [31:0] ctrl_word(input logic [15:0] wspace,
                                            input logic ovf, input logic wi,
                                            input logic ri,  input logic we,
                                            input logic re);
    logic [31:0] w;
    w                   = '0;
    w[OFS_WSPACE +: 16] = wspace;
    w[BIT_OVF]          = ovf;
    w[BIT_WI]           = wi;
    w[BIT_RI]           = ri;
    w[BIT_WE]           = we;
    w[BIT_RE]           = re;
    return w;
  endfunction

endpackage

// File: rtl/jtag_uart_responder_if.sv
// Avalon-MM link between a JTAG UART master and this responder.
interface jtag_uart_responder_if;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, writedata, write, read,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, writedata, write, read,
    output waitrequest, readdata
  );
endinterface

// File: rtl/jtag_uart_responder_fifo.sv
// 8-bit show-ahead FIFO with occupancy count. The head is read
// asynchronously so the stream side can see it without a bubble; at the
// default depth the array maps to distributed RAM.
module jtag_uart_fifo #(
  parameter int LOG_DEPTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [7:0]           push_data,
  input  logic                 pop,
  output logic [7:0]           head,
  output logic [LOG_DEPTH:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int                 DEPTH      = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_reg;
  logic [LOG_DEPTH-1:0] rd_ptr_reg;
  logic [LOG_DEPTH:0]   count_reg;
  logic                 do_push;
  logic                 do_pop;

  // Full/empty are judged on the pre-edge state, so push+pop on a full or
  // empty FIFO only performs the legal half.
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally modulo the depth; count tracks occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/jtag_uart_responder.sv
// JTAG UART register-file responder: Avalon-MM slave with a TX FIFO drained
// by the host stream (out_*) and an RX FIFO filled by the host (in_*).
// Reads take one wait cycle; writes complete with no wait.
// Optional build macro JTAG_UART_WAIT_INJECT_EN adds LFSR-driven random
// wait states in IDLE for stress-testing masters.
module jtag_uart_responder
  import jtag_uart_pkg::*;
#(
  parameter int FIFO_LOG_DEPTH = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  jtag_uart_responder_if.slave        av,
  output logic                        irq,
  output logic                        in_canPut,
  input  logic [7:0]                  in_putData,
  input  logic                        in_put,
  output logic                        out_canGet,
  output logic [7:0]                  out_getData,
  input  logic                        out_get
);

  localparam logic [FIFO_LOG_DEPTH:0] DEPTH_C = (FIFO_LOG_DEPTH + 1)'(1 << FIFO_LOG_DEPTH);

  rd_state_e             state_reg, state_next;
  logic                  re_reg, we_reg, ovf_reg;
  logic [31:0]           readdata_reg;
  logic                  wait_cmb, read_start, write_go;
  logic                  wait_inject;
  logic                  is_ctrl;
  logic                  tx_overflow;
  logic                  ri, wi;
  logic [31:0]           data_now, ctrl_now;

  logic [7:0]            rx_head;
  logic [FIFO_LOG_DEPTH:0] rx_count, tx_count;
  logic                  rx_full, rx_empty, tx_full, tx_empty;

  logic                  unused_bits;
  assign unused_bits = ^{av.address[1:0], av.writedata[31:11], av.writedata[9:8]};

`ifdef JTAG_UART_WAIT_INJECT_EN
  logic [7:0] lfsr_reg;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running outside reset
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_reg <= 8'h01;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign wait_inject = lfsr_reg[0];
`else
  assign wait_inject = 1'b0;
`endif

  assign is_ctrl = (av.address[2] == ADDR_CTRL);

  jtag_uart_fifo #(.LOG_DEPTH(FIFO_LOG_DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_put),
    .push_data (in_putData),
    .pop       (read_start && !is_ctrl),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  jtag_uart_fifo #(.LOG_DEPTH(FIFO_LOG_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (write_go && !is_ctrl),
    .push_data (av.writedata[7:0]),
    .pop       (out_get),
    .head      (out_getData),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Read FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request arbitration: a write wins over a simultaneous read; a read
  // stalls one cycle in IDLE, then RESP returns data regardless of read.
  always_comb begin
    state_next = state_reg;
    wait_cmb   = 1'b0;
    read_start = 1'b0;
    write_go   = 1'b0;
    if (reset) begin
      wait_cmb   = 1'b1;
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (wait_inject && (av.read || av.write)) begin
            wait_cmb = 1'b1;
          end else if (av.write) begin
            write_go = 1'b1;
          end else if (av.read) begin
            wait_cmb   = 1'b1;
            read_start = 1'b1;
            state_next = ST_RESP;
          end
        end
        ST_RESP: begin
          state_next = ST_IDLE;
          write_go   = av.write;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign ri          = re_reg && !rx_empty;
  assign wi          = we_reg && !tx_full;
  assign tx_overflow = write_go && !is_ctrl && tx_full;
  assign data_now    = rx_empty ? 32'h0 : data_word(16'(rx_count - 1'b1), rx_head);
  assign ctrl_now    = ctrl_word(16'(DEPTH_C - tx_count), ovf_reg, wi, ri, we_reg, re_reg);

  // Interrupt enables and sticky overflow; a new overflow beats a clear
  always_ff @(posedge clock) begin
    if (reset) begin
      re_reg  <= 1'b0;
      we_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (write_go && is_ctrl) begin
        re_reg <= av.writedata[BIT_RE];
        we_reg <= av.writedata[BIT_WE];
      end
      if (tx_overflow) begin
        ovf_reg <= 1'b1;
      end else if (write_go && is_ctrl && av.writedata[BIT_OVF]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // Read snapshot taken from pre-edge state when the read is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      readdata_reg <= 32'h0;
    end else if (read_start) begin
      readdata_reg <= is_ctrl ? ctrl_now : data_now;
    end
  end

  assign av.waitrequest = wait_cmb;
  assign av.readdata    = readdata_reg;
  assign irq            = !reset && (ri || wi);
  assign in_canPut      = !reset && !rx_full;
  assign out_canGet     = !tx_empty;

endmodule

// File: tb/tb_jtag_uart_responder.sv
// Bench for jtag_uart_responder: directed scenarios followed by a random
// operation mix, all checked against a queue-based register-file model.
module tb_jtag_uart_responder;

  localparam int DEPTH = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       irq, in_canPut, out_canGet;
  logic [7:0] in_putData, out_getData;
  logic       in_put, out_get;

  jtag_uart_responder_if av();

  jtag_uart_responder #(.FIFO_LOG_DEPTH(6)) dut (
    .clock       (clock),
    .reset       (reset),
    .av          (av),
    .irq         (irq),
    .in_canPut   (in_canPut),
    .in_putData  (in_putData),
    .in_put      (in_put),
    .out_canGet  (out_canGet),
    .out_getData (out_getData),
    .out_get     (out_get)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_re, m_we, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_data();
    logic [31:0] w;
    w = 32'h0;
    if (rx_q.size() > 0) begin
      w[31:16] = 16'(rx_q.size() - 1);
      w[15]    = 1'b1;
      w[7:0]   = rx_q[0];
    end
    return w;
  endfunction

  function automatic logic [31:0] model_ctrl();
    logic [31:0] w;
    w        = 32'h0;
    w[31:16] = 16'(DEPTH - tx_q.size());
    w[10]    = m_ovf;
    w[9]     = m_we && (tx_q.size() < DEPTH);
    w[8]     = m_re && (rx_q.size() > 0);
    w[1]     = m_we;
    w[0]     = m_re;
    return w;
  endfunction

  function automatic logic model_irq();
    return (m_re && rx_q.size() > 0) || (m_we && tx_q.size() < DEPTH);
  endfunction

  // Avalon write, optionally with a simultaneous stream pop of the TX FIFO
  task automatic av_write(input bit ctrl, input logic [31:0] d, input bit get_too);
    int pre;
    pre          = tx_q.size();
    av.address   = ctrl ? 3'b100 : 3'b000;
    av.writedata = d;
    av.write     = 1'b1;
    out_get      = get_too;
    @(negedge clock);
    check("wr_wait", {31'b0, av.waitrequest}, 32'h0);
    if (get_too && pre > 0) check("tx_head_pop", {24'b0, out_getData}, {24'b0, tx_q[0]});
    @(posedge clock); #1;
    av.write = 1'b0;
    out_get  = 1'b0;
    if (get_too && pre > 0) void'(tx_q.pop_front());
    if (ctrl) begin
      m_re = d[0];
      m_we = d[1];
      if (d[10]) m_ovf = 1'b0;
    end else if (pre == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      tx_q.push_back(d[7:0]);
    end
    $display("wr %s %08h get=%0d", ctrl ? "ctrl" : "data", d, get_too);
  endtask

  // Avalon read, optionally with a host put on the accept cycle
  task automatic av_read(input bit ctrl, input bit put_too, input logic [7:0] pb,
                         output logic [31:0] rd);
    logic [31:0] exp;
    int          pre, waits;
    exp        = ctrl ? model_ctrl() : model_data();
    pre        = rx_q.size();
    av.address = ctrl ? 3'b100 : 3'b000;
    av.read    = 1'b1;
    in_put     = put_too;
    in_putData = pb;
    waits      = 0;
    @(negedge clock);
    while (av.waitrequest === 1'b1 && waits < 8) begin
      waits++;
      @(posedge clock); #1;
      in_put = 1'b0;
      @(negedge clock);
    end
    rd = av.readdata;
    check("rd_wait", 32'(waits), 32'd1);
    check(ctrl ? "rd_ctrl" : "rd_data", rd, exp);
    @(posedge clock); #1;
    av.read = 1'b0;
    in_put  = 1'b0;
    if (!ctrl && pre > 0) void'(rx_q.pop_front());
    if (put_too && pre < DEPTH) rx_q.push_back(pb);
    $display("rd %s %08h put=%0d", ctrl ? "ctrl" : "data", rd, put_too);
  endtask

  task automatic host_put(input logic [7:0] pb);
    in_put     = 1'b1;
    in_putData = pb;
    @(negedge clock);
    check("in_canPut", {31'b0, in_canPut}, {31'b0, rx_q.size() < DEPTH});
    @(posedge clock); #1;
    in_put = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(pb);
    $display("put %02h", pb);
  endtask

  task automatic host_get();
    out_get = 1'b1;
    @(negedge clock);
    check("out_canGet", {31'b0, out_canGet}, {31'b0, tx_q.size() > 0});
    if (tx_q.size() > 0) check("out_getData", {24'b0, out_getData}, {24'b0, tx_q[0]});
    @(posedge clock); #1;
    out_get = 1'b0;
    if (tx_q.size() > 0) void'(tx_q.pop_front());
    $display("get");
  endtask

  task automatic status();
    @(negedge clock);
    check("irq", {31'b0, irq}, {31'b0, model_irq()});
    check("st_canPut", {31'b0, in_canPut}, {31'b0, rx_q.size() < DEPTH});
    check("st_canGet", {31'b0, out_canGet}, {31'b0, tx_q.size() > 0});
    @(posedge clock); #1;
    $display("status irq=%0d", irq);
  endtask

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_re  = 1'b0;
    m_we  = 1'b0;
    m_ovf = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          op;

    reset        = 1'b1;
    av.address   = 3'b0;
    av.writedata = 32'h0;
    av.write     = 1'b0;
    av.read      = 1'b0;
    in_put       = 1'b0;
    in_putData   = 8'h0;
    out_get      = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wait",     {31'b0, av.waitrequest}, 32'h1);
    check("rst_canPut",   {31'b0, in_canPut},      32'h0);
    check("rst_irq",      {31'b0, irq},            32'h0);
    check("rst_canGet",   {31'b0, out_canGet},     32'h0);
    check("rst_readdata", av.readdata,             32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    status();

    // Empty RX read
    av_read(1'b0, 1'b0, 8'h00, rd);
    check("rd_empty", rd, 32'h0);

    // Two host bytes then two DATA reads
    host_put(8'h41);
    host_put(8'h42);
    av_read(1'b0, 1'b0, 8'h00, rd);
    check("rd_41", rd, 32'h0001_8041);
    av_read(1'b0, 1'b0, 8'h00, rd);
    check("rd_42", rd, 32'h0000_8042);

    // TX overflow: 65 writes, 65th dropped
    for (int i = 0; i < DEPTH + 1; i++) av_write(1'b0, 32'(i + 16), 1'b0);
    av_read(1'b1, 1'b0, 8'h00, rd);
    check("ctrl_ovf", rd, 32'h0000_0400);
    for (int i = 0; i < DEPTH; i++) host_get();
    status();

    // Clear OVF, enable interrupts, one RX byte
    av_write(1'b1, 32'h400, 1'b0);
    av_read(1'b1, 1'b0, 8'h00, rd);
    check("ctrl_clr", rd, 32'h0040_0000);
    av_write(1'b1, 32'h3, 1'b0);
    host_put(8'h99);
    @(negedge clock);
    check("irq_on", {31'b0, irq}, 32'h1);
    @(posedge clock); #1;
    av_read(1'b1, 1'b0, 8'h00, rd);
    check("ctrl_irq", rd, 32'h0040_0303);

    // Read+write same cycle: only the write happens
    av.address   = 3'b000;
    av.writedata = 32'h55;
    av.write     = 1'b1;
    av.read      = 1'b1;
    @(negedge clock);
    check("rw_wait", {31'b0, av.waitrequest}, 32'h0);
    @(posedge clock); #1;
    av.write = 1'b0;
    av.read  = 1'b0;
    tx_q.push_back(8'h55);
    status();
    host_get();
    av_read(1'b0, 1'b0, 8'h00, rd);

    // Simultaneous push+pop on both FIFOs
    host_put(8'h11);
    host_put(8'h22);
    av_read(1'b0, 1'b1, 8'h33, rd);
    av_write(1'b0, 32'h66, 1'b0);
    av_write(1'b0, 32'h77, 1'b1);
    av_read(1'b1, 1'b0, 8'h00, rd);

    // Random operation mix
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: av_write(1'b0, $urandom, 1'($urandom_range(0, 1)));
        3:       av_write(1'b1, $urandom, 1'b0);
        4:       av_read(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), rd);
        5:       av_read(1'b1, 1'b0, 8'h00, rd);
        6, 7:    host_put(8'($urandom));
        8:       host_get();
        default: status();
      endcase
    end

    // Fill RX past full, then read the RAVAIL boundary
    for (int i = 0; i < DEPTH + 2; i++) host_put(8'(i));
    status();
    av_read(1'b0, 1'b1, 8'hEE, rd);
    av_read(1'b1, 1'b0, 8'h00, rd);

    // Reset while in RESP
    av_write(1'b0, 32'hA5, 1'b0);
    av.address = 3'b000;
    av.read    = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b1;
    av.read = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rr_readdata", av.readdata,         32'h0);
    check("rr_canGet",   {31'b0, out_canGet}, 32'h0);
    check("rr_wait",     {31'b0, av.waitrequest}, 32'h1);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    status();
    av_read(1'b0, 1'b0, 8'h00, rd);
    check("rr_empty", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
